// File: rtl/button_conditioner_pkg.sv
// Shared constants, helper and per-bit status type for the pushbutton
// conditioner that feeds the processor IN port.
package button_conditioner_pkg;

    // Number of buttons wired to the IN port.
    localparam int BTN_WIDTH            = 4;
    // Default number of consecutive disagreeing edges before a level change.
    localparam int BTN_DEBOUNCE_DEFAULT = 16;

    // Width of the debounce counter. The counter only ever holds
    // 0..cycles-1, so clog2(cycles) bits are enough. The floor of 1 bit
    // keeps the declaration legal at the low end of the range.
    function automatic int cnt_width(input int cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

    // Per-bit result handed from the debouncer to the press latch.
    //   level : debounced, synchronized button level
    //   rise  : high during the cycle whose closing edge flips level 0->1
    typedef struct packed {
        logic level;
        logic rise;
    } db_status_t;

endpackage

// File: rtl/debounce_bit.sv
// One button channel: 2-flop synchronizer, saturating debounce counter and
// the debounced level flop. Also reports the 0->1 transition that the
// closing edge is about to make, so the press latch can capture it on the
// same edge as the level change.
module debounce_bit
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = BTN_DEBOUNCE_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       raw,
    output db_status_t status
);

    localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] cnt;

    logic          mismatch;
    logic          expire;
    logic          flip;

    // Two-flop synchronizer; the pin is asynchronous to clock.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Decode of the counter state: does the synchronized input disagree with
    // the level, and has it done so for the full window on this edge.
    always_comb begin
        mismatch = (sync2 != level);
        expire   = (cnt == CNT_LAST);
        flip     = mismatch & expire;
    end

    // Debounce counter and level: any agreeing edge restarts the window, so
    // only DEBOUNCE_CYCLES consecutive disagreeing edges move the level.
    // The counter is cleared at its last value and never wraps.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (!mismatch) begin
            cnt   <= '0;
        end else if (expire) begin
            cnt   <= '0;
            level <= sync2;
        end else begin
            cnt   <= cnt + CNT_ONE;
        end
    end

    // Status out: the rise flag is combinational so that the press latch
    // and the level flop update together.
    always_comb begin
        status.level = level;
        status.rise  = flip & ~level;
    end

endmodule

// File: rtl/button_conditioner.sv
// Conditions raw pushbuttons for the processor IN port: per-bit debounce,
// then a sticky press-event latch that the processor clears by reading.
// Presses shorter than an instruction period are therefore never lost.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int WIDTH           = BTN_WIDTH,
    parameter int DEBOUNCE_CYCLES = BTN_DEBOUNCE_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] buttons_raw,
    input  logic             read_strobe,
    output logic [WIDTH-1:0] buttons_level,
    output logic [WIDTH-1:0] buttons_press,
    output logic             press_pending
);

    db_status_t [WIDTH-1:0] status;
    logic       [WIDTH-1:0] level_vec;
    logic       [WIDTH-1:0] rise_vec;
    logic       [WIDTH-1:0] press_q;
    logic       [WIDTH-1:0] press_d;
    logic                   pending_q;

    // One independent debounce channel per button.
    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_db (
            .clock  (clock),
            .reset  (reset),
            .raw    (buttons_raw[g]),
            .status (status[g])
        );
    end

    // Unpack channel status into plain vectors for the latch logic.
    always_comb begin
        level_vec = '0;
        rise_vec  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            level_vec[i] = status[i].level;
            rise_vec[i]  = status[i].rise;
        end
    end

    // Next press state: a read clears what it saw, but a rise on the same
    // edge wins so a new event is never swallowed by the read.
    always_comb begin
        press_d = rise_vec | (press_q & ~{WIDTH{read_strobe}});
    end

    // Press latch and pending flag; pending is registered from the same
    // next-state so it always agrees with buttons_press.
    always_ff @(posedge clock) begin
        if (reset) begin
            press_q   <= '0;
            pending_q <= 1'b0;
        end else begin
            press_q   <= press_d;
            pending_q <= |press_d;
        end
    end

    assign buttons_level = level_vec;
    assign buttons_press = press_q;
    assign press_pending = pending_q;

endmodule
